// File: rtl/axi_lite_apb_bridge.sv
// AXI4-Lite slave to APB4 master bridge. Every AXI transaction becomes exactly
// one APB transfer. Reads and writes are serialised. When both are waiting,
// the type that was not granted last goes first. An optional ACCESS-phase
// timeout answers SLVERR so that a hung peripheral cannot stall the bus.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | waiting for AW+W or AR; grant and latch request
//   S_SETUP  | APB setup phase, psel=1 penable=0
//   S_ACCESS | APB access phase, wait for pready or timeout
//   S_RESP   | bvalid/rvalid held until the master accepts it
module axi_lite_apb_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              clk_i,
    input  logic              aresetn_i,
    input  logic [ADDR_W-1:0] s_axi_awaddr_i,
    input  logic [2:0]        s_axi_awprot_i,
    input  logic              s_axi_awvalid_i,
    output logic              s_axi_awready_o,
    input  logic [DATA_W-1:0] s_axi_wdata_i,
    input  logic [STRB_W-1:0] s_axi_wstrb_i,
    input  logic              s_axi_wvalid_i,
    output logic              s_axi_wready_o,
    output logic [1:0]        s_axi_bresp_o,
    output logic              s_axi_bvalid_o,
    input  logic              s_axi_bready_i,
    input  logic [ADDR_W-1:0] s_axi_araddr_i,
    input  logic [2:0]        s_axi_arprot_i,
    input  logic              s_axi_arvalid_i,
    output logic              s_axi_arready_o,
    output logic [DATA_W-1:0] s_axi_rdata_o,
    output logic [1:0]        s_axi_rresp_o,
    output logic              s_axi_rvalid_o,
    input  logic              s_axi_rready_i,
    output logic [ADDR_W-1:0] paddr_o,
    output logic              psel_o,
    output logic              penable_o,
    output logic              pwrite_o,
    output logic [DATA_W-1:0] pwdata_o,
    output logic [STRB_W-1:0] pstrb_o,
    output logic [2:0]        pprot_o,
    input  logic [DATA_W-1:0] prdata_i,
    input  logic              pready_i,
    input  logic              pslverr_i
);

    localparam int         CNT_W       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

    state_t             state_q;
    logic               last_wr_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [ADDR_W-1:0]  paddr_q;
    logic               psel_q;
    logic               penable_q;
    logic               pwrite_q;
    logic [DATA_W-1:0]  pwdata_q;
    logic [STRB_W-1:0]  pstrb_q;
    logic [2:0]         pprot_q;
    logic [1:0]         bresp_q;
    logic               bvalid_q;
    logic [DATA_W-1:0]  rdata_q;
    logic [1:0]         rresp_q;
    logic               rvalid_q;

    logic wr_elig, rd_elig, grant_wr, grant_rd, resp_done, access_end;

    // Arbitration: a write needs AW and W together; ties go against the last grant
    always_comb begin
        wr_elig    = s_axi_awvalid_i && s_axi_wvalid_i;
        rd_elig    = s_axi_arvalid_i;
        grant_wr   = aresetn_i && (state_q == S_IDLE) && wr_elig && (!rd_elig || !last_wr_q);
        grant_rd   = aresetn_i && (state_q == S_IDLE) && rd_elig && (!wr_elig || last_wr_q);
        resp_done  = (bvalid_q && s_axi_bready_i) || (rvalid_q && s_axi_rready_i);
        access_end = pready_i || ((TIMEOUT > 0) && (cnt_q == '0));
    end

    // Transfer sequencer with registered APB and response outputs
    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            state_q   <= S_IDLE;
            last_wr_q <= 1'b0;
            cnt_q     <= '0;
            paddr_q   <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            pprot_q   <= '0;
            bresp_q   <= RESP_OKAY;
            bvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_wr) begin
                        paddr_q   <= s_axi_awaddr_i;
                        pwdata_q  <= s_axi_wdata_i;
                        pstrb_q   <= s_axi_wstrb_i;
                        pprot_q   <= s_axi_awprot_i;
                        pwrite_q  <= 1'b1;
                        last_wr_q <= 1'b1;
                        psel_q    <= 1'b1;
                        state_q   <= S_SETUP;
                    end else if (grant_rd) begin
                        paddr_q   <= s_axi_araddr_i;
                        pwdata_q  <= '0;
                        pstrb_q   <= '0;
                        pprot_q   <= s_axi_arprot_i;
                        pwrite_q  <= 1'b0;
                        last_wr_q <= 1'b0;
                        psel_q    <= 1'b1;
                        state_q   <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    penable_q <= 1'b1;
                    cnt_q     <= CNT_W'(TIMEOUT - 1);
                    state_q   <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (access_end) begin
                        // A timeout is the only way out without pready
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        state_q   <= S_RESP;
                        if (pwrite_q) begin
                            bvalid_q <= 1'b1;
                            bresp_q  <= (!pready_i || pslverr_i) ? RESP_SLVERR : RESP_OKAY;
                        end else begin
                            rvalid_q <= 1'b1;
                            rresp_q  <= (!pready_i || pslverr_i) ? RESP_SLVERR : RESP_OKAY;
                            rdata_q  <= pready_i ? prdata_i : '0;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (resp_done) begin
                        bvalid_q <= 1'b0;
                        rvalid_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign s_axi_awready_o = grant_wr;
    assign s_axi_wready_o  = grant_wr;
    assign s_axi_arready_o = grant_rd;
    assign s_axi_bresp_o   = bresp_q;
    assign s_axi_bvalid_o  = bvalid_q;
    assign s_axi_rdata_o   = rdata_q;
    assign s_axi_rresp_o   = rresp_q;
    assign s_axi_rvalid_o  = rvalid_q;
    assign paddr_o         = paddr_q;
    assign psel_o          = psel_q;
    assign penable_o       = penable_q;
    assign pwrite_o        = pwrite_q;
    assign pwdata_o        = pwdata_q;
    assign pstrb_o         = pstrb_q;
    assign pprot_o         = pprot_q;

endmodule

// File: tb/tb_axi_lite_apb_bridge.sv
// Scoreboard bench for axi_lite_apb_bridge: a transaction-level model predicts
// APB transfers and AXI responses; independent monitors compare them.
module tb_axi_lite_apb_bridge;
    localparam int TO = 8;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [31:0] awaddr, wdata, araddr, rdata, paddr, pwdata, prdata;
    logic [2:0]  awprot, arprot, pprot;
    logic [3:0]  wstrb, pstrb;
    logic [1:0]  bresp, rresp;
    logic awvalid, awready, wvalid, wready, bvalid, bready;
    logic arvalid, arready, rvalid, rready;
    logic psel, penable, pwrite, pready, pslverr;

    axi_lite_apb_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk_i(clk), .aresetn_i(rst_n),
        .s_axi_awaddr_i(awaddr), .s_axi_awprot_i(awprot), .s_axi_awvalid_i(awvalid),
        .s_axi_awready_o(awready),
        .s_axi_wdata_i(wdata), .s_axi_wstrb_i(wstrb), .s_axi_wvalid_i(wvalid),
        .s_axi_wready_o(wready),
        .s_axi_bresp_o(bresp), .s_axi_bvalid_o(bvalid), .s_axi_bready_i(bready),
        .s_axi_araddr_i(araddr), .s_axi_arprot_i(arprot), .s_axi_arvalid_i(arvalid),
        .s_axi_arready_o(arready),
        .s_axi_rdata_o(rdata), .s_axi_rresp_o(rresp), .s_axi_rvalid_o(rvalid),
        .s_axi_rready_i(rready),
        .paddr_o(paddr), .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
        .pwdata_o(pwdata), .pstrb_o(pstrb), .pprot_o(pprot),
        .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
    );

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int          len;
    } apb_t;
    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
    } rsp_t;

    apb_t exp_apb[$];
    rsp_t exp_b[$], exp_r[$];
    logic [31:0] ref_mem [16];
    logic [31:0] slave_mem [16];
    int cur_wait = 0;
    bit cur_err = 0;
    int rdy_mode = 1;
    int cyc = 0;
    int b_rise = 0, r_rise = 0;
    int n_checks = 0, n_fail = 0;

    logic [114:0] all_out;
    assign all_out = {awready, wready, arready, bvalid, bresp, rvalid, rresp, rdata,
                      paddr, psel, penable, pwrite, pwdata, pstrb, pprot};

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk_eq(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r = o;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    // Reference model: one APB transfer and one response per request
    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                               input logic [2:0] p, input int w, input bit e);
        bit tmo = (w >= TO);
        bit err = e || tmo;
        apb_t t = '{a, 1'b1, d, s, p, tmo ? TO : w + 1};
        rsp_t r = '{err ? 2'b10 : 2'b00, 32'h0};
        exp_apb.push_back(t);
        exp_b.push_back(r);
        if (!err) ref_mem[a[5:2]] = merge(ref_mem[a[5:2]], d, s);
    endtask

    task automatic model_read(input logic [31:0] a, input logic [2:0] p, input int w, input bit e);
        bit tmo = (w >= TO);
        apb_t t = '{a, 1'b0, 32'h0, 4'h0, p, tmo ? TO : w + 1};
        rsp_t r = '{(e || tmo) ? 2'b10 : 2'b00, tmo ? 32'h0 : ref_mem[a[5:2]]};
        exp_apb.push_back(t);
        exp_r.push_back(r);
    endtask

    task automatic wait_hs(input bit wr, output int gc);
        bit got = 0;
        gc = -1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (wr ? (awready && wready) : arready) begin got = 1; gc = cyc; end
            @(posedge clk); #1;
        end
        chk_eq(wr ? "write_handshake" : "read_handshake", got, 1);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [2:0] p, input int w, input bit e, output int gc);
        model_write(a, d, s, p, w, e);
        cur_wait = w; cur_err = e;
        awaddr = a; awprot = p; wdata = d; wstrb = s;
        awvalid = 1; wvalid = 1;
        wait_hs(1, gc);
        awvalid = 0; wvalid = 0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [2:0] p, input int w, input bit e,
                           output int gc);
        model_read(a, p, w, e);
        cur_wait = w; cur_err = e;
        araddr = a; arprot = p; arvalid = 1;
        wait_hs(0, gc);
        arvalid = 0;
    endtask

    task automatic wait_idle();
        bit idle = 0;
        for (int i = 0; i < 300 && !idle; i++) begin
            @(posedge clk); #1;
            idle = (exp_b.size() == 0) && (exp_r.size() == 0);
        end
        chk_eq("drain_responses", idle, 1);
    endtask

    // One half of a write arrives first; nothing may be accepted until the other half
    task automatic lone_test(input bit aw_first, input logic [31:0] a, input logic [31:0] d);
        int gc;
        model_write(a, d, 4'b0101, 3'b100, 0, 0);
        cur_wait = 0; cur_err = 0;
        awaddr = a; awprot = 3'b100; wdata = d; wstrb = 4'b0101;
        if (aw_first) awvalid = 1; else wvalid = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_eq("lone_half_no_ready", {awready, wready, arready}, 3'b000);
            @(posedge clk); #1;
        end
        awvalid = 1; wvalid = 1;
        wait_hs(1, gc);
        awvalid = 0; wvalid = 0;
        wait_idle();
    endtask

    // APB slave: pready after cur_wait extra ACCESS cycles, noise otherwise
    initial begin
        int acnt = 0;
        pready = 0; pslverr = 0; prdata = 0;
        forever begin
            @(negedge clk);
            if (!rst_n || !(psel && penable)) begin
                pready = 0; pslverr = 0; acnt = 0; prdata = $urandom;
            end else begin
                if (acnt == cur_wait) begin
                    pready = 1; pslverr = cur_err;
                    if (pwrite) begin
                        if (!cur_err) slave_mem[paddr[5:2]] = merge(slave_mem[paddr[5:2]], pwdata, pstrb);
                    end else prdata = slave_mem[paddr[5:2]];
                end else begin
                    pready = 0; pslverr = 1'($urandom_range(0, 1)); prdata = $urandom;
                end
                acnt++;
            end
        end
    end

    // Response ready generator
    initial begin
        bready = 0; rready = 0;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: begin bready = ($urandom_range(0, 2) != 0); rready = ($urandom_range(0, 2) != 0); end
                2: begin bready = 1; rready = 0; end
                default: begin bready = 1; rready = 1; end
            endcase
        end
    end

    // APB monitor: ordering, field stability and ACCESS length
    initial begin
        apb_t cur;
        bit active = 0;
        int acc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active = 0; acc = 0;
            end else if (psel && !penable) begin
                chk_eq("apb_transfer_expected", exp_apb.size() != 0, 1);
                if (exp_apb.size() != 0) begin
                    cur = exp_apb.pop_front();
                    active = 1; acc = 0;
                    chk_eq("apb_setup_fields", {paddr, pwrite, cur.wr ? pwdata : 32'h0, pstrb, pprot},
                           {cur.addr, cur.wr, cur.wdata, cur.strb, cur.prot});
                end
            end else if (psel && penable) begin
                acc++;
                if (active)
                    chk_eq("apb_access_stable", {paddr, pwrite, cur.wr ? pwdata : 32'h0, pstrb, pprot},
                           {cur.addr, cur.wr, cur.wdata, cur.strb, cur.prot});
            end else if (active) begin
                chk_eq("apb_access_len", acc, cur.len);
                active = 0;
            end
        end
    end

    // AXI response monitor
    initial begin
        rsp_t e;
        logic pb_valid = 0, pr_valid = 0, pr_ready = 0;
        logic [1:0] pr_resp = 0;
        logic [31:0] pr_data = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pb_valid = 0; pr_valid = 0; pr_ready = 0;
            end else begin
                if (bvalid && !pb_valid) b_rise = cyc;
                if (rvalid && !pr_valid) r_rise = cyc;
                if (pr_valid && !pr_ready)
                    chk_eq("r_hold_stable", {rvalid, rresp, rdata}, {1'b1, pr_resp, pr_data});
                if (awready || wready) chk_eq("aw_w_ready_pair", awready, wready);
                if (bvalid && bready) begin
                    chk_eq("b_expected", exp_b.size() != 0, 1);
                    if (exp_b.size() != 0) begin
                        e = exp_b.pop_front();
                        chk_eq("bresp", bresp, e.resp);
                    end
                end
                if (rvalid && rready) begin
                    chk_eq("r_expected", exp_r.size() != 0, 1);
                    if (exp_r.size() != 0) begin
                        e = exp_r.pop_front();
                        chk_eq("rresp_rdata", {rresp, rdata}, {e.resp, e.data});
                    end
                end
                pb_valid = bvalid; pr_valid = rvalid; pr_ready = rready;
                pr_resp = rresp; pr_data = rdata;
            end
        end
    end

    initial begin
        int gc, seen, ng;
        logic [3:0] ord;
        int wl [8] = '{0, 0, 1, 2, 3, 7, 8, 12};
        awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
        araddr = 0; arprot = 0; arvalid = 0;
        for (int i = 0; i < 16; i++) begin ref_mem[i] = 0; slave_mem[i] = 0; end

        repeat (3) @(posedge clk); #1;
        chk_eq("reset_outputs", all_out, 0);
        rst_n = 1;
        @(posedge clk); #1;

        // Continuous AW+W+AR: first tie after reset goes to write, then alternate
        model_write(32'h40, 32'hA5A5_0001, 4'hF, 3'b001, 0, 0);
        model_read (32'h40, 3'b010, 0, 0);
        model_write(32'h40, 32'hA5A5_0001, 4'hF, 3'b001, 0, 0);
        model_read (32'h40, 3'b010, 0, 0);
        cur_wait = 0; cur_err = 0;
        awaddr = 32'h40; awprot = 3'b001; wdata = 32'hA5A5_0001; wstrb = 4'hF;
        araddr = 32'h40; arprot = 3'b010;
        awvalid = 1; wvalid = 1; arvalid = 1;
        ord = 0; ng = 0;
        for (int i = 0; i < 100 && ng < 4; i++) begin
            @(negedge clk);
            if (awready && wready) begin ord = {ord[2:0], 1'b1}; ng++; end
            else if (arready) begin ord = {ord[2:0], 1'b0}; ng++; end
            @(posedge clk); #1;
        end
        awvalid = 0; wvalid = 0; arvalid = 0;
        chk_eq("grant_order_WRWR", ord, 4'b1010);
        wait_idle();

        do_write(32'h10, 32'hDEADBEEF, 4'hF, 3'b000, 0, 0, gc);
        wait_idle();
        chk_eq("write_latency", b_rise - gc, 3);

        slave_mem[8] = 32'h12345678; ref_mem[8] = 32'h12345678;
        do_read(32'h20, 3'b000, 3, 0, gc);
        wait_idle();
        chk_eq("read_3wait_latency", r_rise - gc, 6);
        do_read(32'h10, 3'b101, 0, 0, gc);
        wait_idle();
        chk_eq("read_latency", r_rise - gc, 3);

        lone_test(1, 32'h30, 32'hCAFE_F00D);
        lone_test(0, 32'h34, 32'h0BAD_1DEA);

        do_write(32'h30, 32'hFFFF_FFFF, 4'h0, 3'b000, 0, 0, gc);
        wait_idle();
        do_read(32'h30, 3'b000, 1, 0, gc);
        wait_idle();

        do_write(32'h14, 32'h7777_7777, 4'hF, 3'b000, 1, 1, gc);
        wait_idle();
        do_read(32'h10, 3'b000, 2, 1, gc);
        wait_idle();

        rdy_mode = 2;
        do_read(32'h20, 3'b000, 0, 0, gc);
        for (int i = 0; i < 20 && !rvalid; i++) @(negedge clk);
        repeat (10) @(negedge clk);
        chk_eq("rvalid_held_10", rvalid, 1);
        @(posedge clk); #1;
        rdy_mode = 1;
        wait_idle();

        do_read(32'h20, 3'b000, 100, 0, gc);
        wait_idle();
        do_write(32'h18, 32'h1111_2222, 4'hF, 3'b000, 7, 0, gc);
        wait_idle();
        do_write(32'h18, 32'h3333_4444, 4'hF, 3'b000, 8, 0, gc);
        wait_idle();
        do_read(32'h18, 3'b000, 0, 0, gc);
        wait_idle();

        // Reset in the middle of a hung ACCESS phase
        do_read(32'h20, 3'b000, 100, 0, gc);
        seen = 0;
        for (int i = 0; i < 20 && seen < 2; i++) begin
            @(negedge clk);
            if (psel && penable) seen++;
        end
        chk_eq("reached_access", seen, 2);
        rst_n = 0;
        #1;
        chk_eq("reset_mid_access_outputs", all_out, 0);
        exp_r.delete();
        repeat (2) @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        do_write(32'h1C, 32'h5555_AAAA, 4'hF, 3'b011, 0, 0, gc);
        wait_idle();
        chk_eq("post_reset_write_latency", b_rise - gc, 3);
        do_read(32'h1C, 3'b011, 1, 0, gc);
        wait_idle();

        rdy_mode = 0;
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a = 32'h4000_0000 | (32'($urandom_range(0, 15)) << 2);
            int w = wl[$urandom_range(0, 7)];
            bit e = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), w, e, gc);
            else
                do_read(a, 3'($urandom_range(0, 7)), w, e, gc);
            wait_idle();
        end

        repeat (5) @(posedge clk); #1;
        chk_eq("apb_queue_empty", exp_apb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
